ripple_count_capture: RTL and testbench

- Downstream consumer of the 3-bit T-flip-flop ripple counter. Its input is asynchronous to clk_i and glitches while bits ripple.
- Synchronizes the raw count into the clk_i domain and accepts a value only after it has been stable for STABLE consecutive samples.
- Converts each accepted change into a modulo-2^N increment (delta) and accumulates it into a wide event count.
- Presents each delta on a valid/ready interface to downstream logic.

---
 rtl/ripple_count_capture.sv | 139 +++++++++++++
 tb/tb_ripple_count_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - filters, differences and accumulates an asynchronous ripple counter value
module ripple_count_capture #(
    parameter int N      = 3,
    parameter int W      = 16,
    parameter int STABLE = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] cnt_i,
    input  logic         clr_i,
    input  logic         ready_i,
    output logic [W-1:0] count_o,
    output logic [N-1:0] delta_o,
    output logic         valid_o,
    output logic         ovf_o
);

    localparam int RW = 4;
    localparam logic [RW-1:0] STABLE_R = RW'(STABLE);

    typedef enum logic {INIT, TRACK} state_t;

    state_t         state, state_next;
    logic [N-1:0]   s1, s2;
    logic           fill1, fill2;
    logic [N-1:0]   cand;
    logic [RW-1:0]  run, run_next;
    logic [N-1:0]   baseline;
    logic           accept;

    logic [N-1:0]   d;
    logic           event_hit;
    logic           handshake;
    logic           hold_merge;
    logic [W:0]     count_sum;
    logic [N:0]     merge_sum;
    logic           merge_sat;

    // Two-flop synchronizer; fill1/fill2 mark when s2 holds a real sample
    // rather than its reset zero, so the filter never accepts that zero.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1    <= '0;
            s2    <= '0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
        end else begin
            s1    <= cnt_i;
            s2    <= s1;
            fill1 <= 1'b1;
            fill2 <= fill1;
        end
    end

    // Run-length of the current candidate, saturating at STABLE.
    always_comb begin
        run_next = run;
        if (fill2) begin
            if (s2 == cand)
                run_next = (run >= STABLE_R) ? STABLE_R : run + RW'(1);
            else
                run_next = RW'(1);
        end
    end

    assign accept = fill2 && (run_next == STABLE_R) && (run < STABLE_R);

    // Candidate register follows the synchronized value once samples are real.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cand <= '0;
            run  <= '0;
        end else begin
            if (fill2)
                cand <= s2;
            run <= run_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            state <= INIT;
        else
            state <= state_next;
    end

    // FSM next state: the first accepted value moves INIT to TRACK.
    always_comb begin
        state_next = state;
        if (accept)
            state_next = TRACK;
    end

    // FSM outputs: modulo increment, event qualification and merge arithmetic.
    // On accept cand equals s2, so s2 is the accepted value.
    always_comb begin
        d          = s2 - baseline;
        event_hit  = accept && (state == TRACK) && (d != '0);
        handshake  = valid_o && ready_i;
        hold_merge = valid_o && !ready_i;
        count_sum  = {1'b0, count_o} + {{(W + 1 - N){1'b0}}, d};
        merge_sum  = {1'b0, delta_o} + {1'b0, d};
        merge_sat  = merge_sum[N];
    end

    // Accumulator, pending delta and sticky overflow; clear wins over events.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            baseline <= '0;
            count_o  <= '0;
            delta_o  <= '0;
            valid_o  <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (accept)
                baseline <= s2;
            if (clr_i) begin
                count_o <= '0;
                delta_o <= '0;
                valid_o <= 1'b0;
                ovf_o   <= 1'b0;
            end else if (event_hit) begin
                count_o <= count_sum[W-1:0];
                if (hold_merge) begin
                    delta_o <= merge_sat ? {N{1'b1}} : merge_sum[N-1:0];
                    ovf_o   <= ovf_o | count_sum[W] | merge_sat;
                end else begin
                    delta_o <= d;
                    valid_o <= 1'b1;
                    ovf_o   <= ovf_o | count_sum[W];
                end
            end else if (handshake) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb/tb_ripple_count_capture.sv - directed self-checking bench for ripple_count_capture
module tb_ripple_count_capture;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [2:0] cnt_i;
    logic       clr_i;
    logic       ready_i;
    logic [3:0] count_o;
    logic [2:0] delta_o;
    logic       valid_o;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    ripple_count_capture #(.N(3), .W(4), .STABLE(2)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .cnt_i   (cnt_i),
        .clr_i   (clr_i),
        .ready_i (ready_i),
        .count_o (count_o),
        .delta_o (delta_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] v);
        cnt_i = v;
        repeat (4) tick();
    endtask

    task automatic settle();
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset_i = 1'b0; cnt_i = 3'd5; clr_i = 1'b0; ready_i = 1'b1;
        #12;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (delta_o !== 3'd0) begin errors++; $display("FAIL reset_delta got %0d want 0", delta_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf_o); end
        reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL init_quiet cycle %0d got valid %0b count %0d want 0 0", i, valid_o, count_o); end
        end
    endtask

    task automatic test_single();
        cnt_i = 3'd6;
        repeat (3) tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_early got valid %0b want 0", valid_o); end
        tick();
        checks++; if (count_o !== 4'd1 || delta_o !== 3'd1 || valid_o !== 1'b1) begin errors++; $display("FAIL single_edge4 got count %0d delta %0d valid %0b want 1 1 1", count_o, delta_o, valid_o); end
        tick();
        checks++; if (valid_o !== 1'b0 || delta_o !== 3'd1) begin errors++; $display("FAIL single_drop got valid %0b delta %0d want 0 1", valid_o, delta_o); end
        tick();
    endtask

    task automatic test_glitch();
        step(3'd2);
        checks++; if (count_o !== 4'd5 || delta_o !== 3'd4) begin errors++; $display("FAIL glitch_setup got count %0d delta %0d want 5 4", count_o, delta_o); end
        settle();
        cnt_i = 3'd3;
        tick();
        cnt_i = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0 || count_o !== 4'd5) begin errors++; $display("FAIL glitch_quiet cycle %0d got valid %0b count %0d want 0 5", i, valid_o, count_o); end
        end
    endtask

    task automatic test_wrap();
        step(3'd7);
        checks++; if (count_o !== 4'd10) begin errors++; $display("FAIL wrap_setup got count %0d want 10", count_o); end
        settle();
        step(3'd1);
        checks++; if (delta_o !== 3'd2 || count_o !== 4'd12 || valid_o !== 1'b1) begin errors++; $display("FAIL wrap_delta got delta %0d count %0d valid %0b want 2 12 1", delta_o, count_o, valid_o); end
        settle();
    endtask

    task automatic test_backpressure();
        reset_i = 1'b0;
        #2;
        reset_i = 1'b1;
        cnt_i = 3'd0;
        repeat (6) tick();
        checks++; if (count_o !== 4'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_base got count %0d valid %0b want 0 0", count_o, valid_o); end
        ready_i = 1'b0;
        step(3'd4);
        checks++; if (delta_o !== 3'd4 || valid_o !== 1'b1 || count_o !== 4'd4 || ovf_o !== 1'b0) begin errors++; $display("FAIL bp_first got delta %0d valid %0b count %0d ovf %0b want 4 1 4 0", delta_o, valid_o, count_o, ovf_o); end
        settle();
        checks++; if (delta_o !== 3'd4 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got delta %0d valid %0b want 4 1", delta_o, valid_o); end
        step(3'd0);
        checks++; if (delta_o !== 3'd7 || ovf_o !== 1'b1 || count_o !== 4'd8) begin errors++; $display("FAIL bp_sat got delta %0d ovf %0b count %0d want 7 1 8", delta_o, ovf_o, count_o); end
        settle();
        step(3'd4);
        settle();
        checks++; if (delta_o !== 3'd7 || count_o !== 4'd12 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_third got delta %0d count %0d valid %0b want 7 12 1", delta_o, count_o, valid_o); end
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0 || count_o !== 4'd12 || delta_o !== 3'd7) begin errors++; $display("FAIL bp_release got valid %0b count %0d delta %0d want 0 12 7", valid_o, count_o, delta_o); end
    endtask

    task automatic test_near_wrap_clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++; if (count_o !== 4'd0 || ovf_o !== 1'b0 || valid_o !== 1'b0 || delta_o !== 3'd0) begin errors++; $display("FAIL clr_first got count %0d ovf %0b valid %0b delta %0d want 0 0 0 0", count_o, ovf_o, valid_o, delta_o); end
        step(3'd2); settle();
        step(3'd0); settle();
        step(3'd2);
        checks++; if (count_o !== 4'd14 || ovf_o !== 1'b0) begin errors++; $display("FAIL nearwrap_14 got count %0d ovf %0b want 14 0", count_o, ovf_o); end
        settle();
        step(3'd5);
        checks++; if (count_o !== 4'd1 || ovf_o !== 1'b1 || delta_o !== 3'd3) begin errors++; $display("FAIL nearwrap_wrap got count %0d ovf %0b delta %0d want 1 1 3", count_o, ovf_o, delta_o); end
        settle();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++; if (count_o !== 4'd0 || ovf_o !== 1'b0) begin errors++; $display("FAIL clr_second got count %0d ovf %0b want 0 0", count_o, ovf_o); end
        step(3'd0);
        checks++; if (count_o !== 4'd3 || delta_o !== 3'd3 || valid_o !== 1'b1) begin errors++; $display("FAIL clr_after got count %0d delta %0d valid %0b want 3 3 1", count_o, delta_o, valid_o); end
        settle();
        cnt_i = 3'd1;
        repeat (3) tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++; if (count_o !== 4'd0 || valid_o !== 1'b0 || delta_o !== 3'd0) begin errors++; $display("FAIL clr_accept got count %0d valid %0b delta %0d want 0 0 0", count_o, valid_o, delta_o); end
        settle();
        step(3'd3);
        checks++; if (count_o !== 4'd2 || delta_o !== 3'd2) begin errors++; $display("FAIL clr_baseline got count %0d delta %0d want 2 2", count_o, delta_o); end
        settle();
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        step(3'd6);
        checks++; if (delta_o !== 3'd3 || valid_o !== 1'b1 || count_o !== 4'd5) begin errors++; $display("FAIL areset_setup got delta %0d valid %0b count %0d want 3 1 5", delta_o, valid_o, count_o); end
        #3;
        reset_i = 1'b0;
        #1;
        checks++; if (count_o !== 4'd0 || delta_o !== 3'd0 || valid_o !== 1'b0 || ovf_o !== 1'b0) begin errors++; $display("FAIL areset_clear got count %0d delta %0d valid %0b ovf %0b want 0 0 0 0", count_o, delta_o, valid_o, ovf_o); end
        #2;
        reset_i = 1'b1;
        repeat (6) tick();
        checks++; if (valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL areset_init got valid %0b count %0d want 0 0", valid_o, count_o); end
        ready_i = 1'b1;
        step(3'd1);
        checks++; if (delta_o !== 3'd3 || count_o !== 4'd3 || valid_o !== 1'b1) begin errors++; $display("FAIL areset_track got delta %0d count %0d valid %0b want 3 3 1", delta_o, count_o, valid_o); end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_wrap();
        test_backpressure();
        test_near_wrap_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
